// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment digit sequencer.
// Segment order is a..g in bits 0..6, decimal point in bit 7, all active-low.
package seg_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        PAUSED = 1'b1
    } seq_state_e;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Glyphs 0-9, A, b, C, d, E, F with dp off; entry 0 sits in the lowest byte.
    localparam logic [15:0][7:0] SEG_LUT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/seg_debounce.sv
// Two-flop synchroniser plus debounce filter for a raw push button.
// level is the accepted button level; press pulses for one cycle when it rises.
module seg_debounce #(
    parameter int DEBOUNCE_CYCLES = 120_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            level   <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            press   <= 1'b0;
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // This sample completes the run of differing samples.
                level <= sync_p1;
                cnt   <= '0;
                press <= sync_p1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_digit_sequencer.sv
// Prescaled up/down digit counter with debounced pause toggle and registered segment output.
// Build macro DP_BLINK_EN: prescaler free-runs while paused and blinks the decimal point.
module seg_digit_sequencer
    import seg_pkg::*;
#(
    parameter int PRESCALE        = 12_000_000,
    parameter int DEBOUNCE_CYCLES = 120_000,
    parameter int MAX_DIGIT       = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_pause,
    input  logic       btn_dir,
    output logic [7:0] sevenseg_out,
    output logic [3:0] digit_out,
    output logic       tick_out,
    output logic       paused
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [3:0]    DIGIT_MAX = 4'(MAX_DIGIT);
`ifdef DP_BLINK_EN
    localparam bit PRE_FREE = 1'b1;
`else
    localparam bit PRE_FREE = 1'b0;
`endif

    logic          press;
    logic          pause_level_unused;
    logic          dir_p0;
    logic          dir_p1;
    seq_state_e    state_q;
    seq_state_e    state_d;
    logic [PW-1:0] pre_q;
    logic [3:0]    digit_q;
    logic [6:0]    seg_p1;
    logic          dp_q;
    logic          terminal;
    logic          tick;

    seg_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_pause_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (btn_pause),
        .level(pause_level_unused),
        .press(press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_p0 <= 1'b0;
            dir_p1 <= 1'b0;
        end else begin
            dir_p0 <= btn_dir;
            dir_p1 <= dir_p0;
        end
    end

    assign terminal = (pre_q == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // A press coinciding with a tick still lets the step happen before pausing.
    always_comb begin
        state_d = state_q;
        tick    = 1'b0;
        if (state_q == RUN && terminal) tick = 1'b1;
        if (press) state_d = (state_q == RUN) ? PAUSED : RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else if (state_q == RUN || PRE_FREE) begin
            pre_q <= terminal ? '0 : pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= 4'd0;
        end else if (tick) begin
            if (dir_p1) digit_q <= (digit_q == 4'd0) ? DIGIT_MAX : digit_q - 1'b1;
            else        digit_q <= (digit_q == DIGIT_MAX) ? 4'd0 : digit_q + 1'b1;
        end
    end

`ifdef DP_BLINK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_q <= 1'b1;
        end else if (state_q == PAUSED) begin
            if (press)         dp_q <= 1'b1;
            else if (terminal) dp_q <= ~dp_q;
        end
    end
`else
    assign dp_q = 1'b1;
`endif

    // Output stage: segment pattern lags the digit register by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) seg_p1 <= SEG_LUT[0][SEG_G:SEG_A];
        else        seg_p1 <= SEG_LUT[digit_q][SEG_G:SEG_A];
    end

    assign sevenseg_out[SEG_G:SEG_A] = seg_p1;
    assign sevenseg_out[SEG_DP]      = dp_q;
    assign digit_out                 = digit_q;
    assign tick_out                  = tick;
    assign paused                    = (state_q == PAUSED);

endmodule

// File: tb/tb_seg_digit_sequencer.sv
// Randomised and directed bench for seg_digit_sequencer against a behavioural model.
// Compile with DP_BLINK_EN defined to exercise the decimal-point blink build.
module tb_seg_digit_sequencer;

    localparam int P  = 4;
    localparam int DB = 3;
    localparam int MD = 9;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       btn_pause = 1'b0;
    logic       btn_dir   = 1'b0;
    logic [7:0] sevenseg_out;
    logic [3:0] digit_out;
    logic       tick_out;
    logic       paused;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_digit_sequencer #(
        .PRESCALE       (P),
        .DEBOUNCE_CYCLES(DB),
        .MAX_DIGIT      (MD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_pause   (btn_pause),
        .btn_dir     (btn_dir),
        .sevenseg_out(sevenseg_out),
        .digit_out   (digit_out),
        .tick_out    (tick_out),
        .paused      (paused)
    );

    // Behavioural model: active-high gfedcba glyphs, inverted on use.
    logic [6:0] hi_pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int         m_digit = 0;
    int         m_pre   = 0;
    bit         m_paused = 1'b0;
    bit         m_pend  = 1'b0;
    bit         m_acc   = 1'b0;
    bit         m_dp    = 1'b1;
    logic [6:0] m_seg   = 7'h40;
    bit         rawq[$];
    bit         dirq[$];
    bit         m_tick, m_was_paused, m_flip;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_digit = 0; m_pre = 0; m_paused = 1'b0; m_pend = 1'b0;
            m_acc = 1'b0; m_dp = 1'b1; m_seg = ~hi_pat[0];
            rawq.delete(); dirq.delete();
            for (int k = 0; k < 6; k++) rawq.push_back(1'b0);
            for (int k = 0; k < 3; k++) dirq.push_back(1'b0);
        end else begin
            // Index 2 of each history is the level the design sees after two sync flops.
            rawq.push_front(btn_pause); void'(rawq.pop_back());
            dirq.push_front(btn_dir);
            m_tick       = !m_paused && (m_pre == P - 1);
            m_was_paused = m_paused;
            m_seg        = ~hi_pat[m_digit];
            if (m_tick)
                m_digit = dirq[2] ? (m_digit + MD) % (MD + 1) : (m_digit + 1) % (MD + 1);
            void'(dirq.pop_back());
`ifdef DP_BLINK_EN
            if (m_was_paused && m_pend)             m_dp = 1'b1;
            else if (m_was_paused && m_pre == P - 1) m_dp = !m_dp;
            m_pre = (m_pre + 1) % P;
`else
            if (!m_was_paused) m_pre = (m_pre + 1) % P;
`endif
            if (m_pend) m_paused = !m_paused;
            m_flip = 1'b1;
            for (int k = 2; k < 2 + DB; k++) if (rawq[k] == m_acc) m_flip = 1'b0;
            m_pend = m_flip && !m_acc;
            if (m_flip) m_acc = !m_acc;
        end
    end

    logic [13:0] exp_vec;
    logic [13:0] dut_vec;
    assign exp_vec = {m_dp, m_seg, 4'(m_digit), (!m_paused && m_pre == P - 1), m_paused};
    assign dut_vec = {sevenseg_out, digit_out, tick_out, paused};

    task automatic test_reset();
        int n;
        rst_n = 1'b0; btn_pause = 1'b0; btn_dir = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec !== {8'hC0, 4'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got %h required %h", dut_vec, {8'hC0, 6'h0});
        end
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk); n++;
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL first_tick_model: got %h required %h", dut_vec, exp_vec);
            end
        end while (!tick_out && n < 10);
        checks++;
        if (n != 3) begin errors++; $display("FAIL first_tick_cycle: got %0d required 3", n); end
        @(negedge clk);
        checks++;
        if (digit_out !== 4'd1) begin errors++; $display("FAIL first_digit: got %0d required 1", digit_out); end
        @(negedge clk);
        checks++;
        if (sevenseg_out !== 8'hF9) begin errors++; $display("FAIL first_seg: got %h required f9", sevenseg_out); end
    endtask

    task automatic test_count_up();
        int ticks = 0;
        btn_dir = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (tick_out) ticks++;
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL count_up: got %h required %h", dut_vec, exp_vec);
            end
        end
        checks++;
        if (ticks != 10) begin errors++; $display("FAIL tick_rate: got %0d required 10", ticks); end
    endtask

    task automatic test_count_down();
        btn_dir = 1'b1;
        repeat (30) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL count_down: got %h required %h", dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_pause();
        logic [3:0] held;
        int pulse_len [3] = '{1, 2, 6};
        for (int i = 0; i < 3; i++) begin
            btn_pause = 1'b1;
            repeat (pulse_len[i]) begin
                @(negedge clk);
                checks++;
                if (dut_vec !== exp_vec) begin
                    errors++; $display("FAIL pause_hold: got %h required %h", dut_vec, exp_vec);
                end
            end
            btn_pause = 1'b0;
            repeat (10) begin
                @(negedge clk);
                checks++;
                if (dut_vec !== exp_vec) begin
                    errors++; $display("FAIL pause_gap: got %h required %h", dut_vec, exp_vec);
                end
            end
            checks++;
            if (paused !== (i == 2)) begin
                errors++; $display("FAIL pause_filter%0d: got %b required %b", i, paused, i == 2);
            end
        end
        held = digit_out;
        repeat (40) begin
            @(negedge clk);
            checks++;
            if (digit_out !== held || dut_vec !== exp_vec) begin
                errors++; $display("FAIL pause_frozen: got %h required %h digit %0d", dut_vec, exp_vec, held);
            end
        end
        btn_pause = 1'b1;
        repeat (6) @(negedge clk);
        btn_pause = 1'b0;
        repeat (24) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL resume: got %h required %h", dut_vec, exp_vec);
            end
        end
        checks++;
        if (paused !== 1'b0) begin errors++; $display("FAIL resume_state: got %b required 0", paused); end
    endtask

    task automatic test_random();
        for (int s = 0; s < 60; s++) begin
            btn_pause = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) btn_dir = ~btn_dir;
            repeat ($urandom_range(1, 10)) begin
                @(negedge clk);
                checks++;
                if (dut_vec !== exp_vec) begin
                    errors++; $display("FAIL random: got %h required %h", dut_vec, exp_vec);
                end
            end
        end
        btn_pause = 1'b0;
        repeat (12) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL random_tail: got %h required %h", dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_reset_midcount();
        int n = 0;
        if (m_paused) begin
            btn_pause = 1'b1;
            repeat (6) @(negedge clk);
            btn_pause = 1'b0;
            repeat (12) @(negedge clk);
        end
        while (digit_out != 4'd5 && n < 200) begin
            @(negedge clk); n++;
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL seek5: got %h required %h", dut_vec, exp_vec);
            end
        end
        checks++;
        if (digit_out !== 4'd5) begin errors++; $display("FAIL seek5_timeout: got %0d required 5", digit_out); end
        @(negedge clk);
        checks++;
        if (sevenseg_out !== 8'h92) begin errors++; $display("FAIL seg5: got %h required 92", sevenseg_out); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== {8'hC0, 4'h0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL midcount_reset: got %h required %h", dut_vec, {8'hC0, 6'h0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL after_reset: got %h required %h", dut_vec, exp_vec);
            end
        end
    endtask

`ifdef DP_BLINK_EN
    task automatic test_dp_blink();
        int   toggles = 0;
        int   n = 0;
        logic prev;
        btn_pause = 1'b1;
        repeat (6) @(negedge clk);
        btn_pause = 1'b0;
        repeat (4) @(negedge clk);
        prev = sevenseg_out[7];
        repeat (24) begin
            @(negedge clk);
            if (sevenseg_out[7] !== prev) toggles++;
            prev = sevenseg_out[7];
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL blink: got %h required %h", dut_vec, exp_vec);
            end
        end
        checks++;
        if (toggles != 6) begin errors++; $display("FAIL blink_rate: got %0d required 6", toggles); end
        repeat (8) @(negedge clk);
        btn_pause = 1'b1;
        repeat (6) @(negedge clk);
        btn_pause = 1'b0;
        while (paused && n < 12) begin @(negedge clk); n++; end
        checks++;
        if (paused !== 1'b0 || sevenseg_out[7] !== 1'b1) begin
            errors++; $display("FAIL blink_resume: got paused %b dp %b required 0 1", paused, sevenseg_out[7]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_pause();
        test_random();
        test_reset_midcount();
`ifdef DP_BLINK_EN
        test_dp_blink();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
